// File: rtl/draw_scheduler.sv
// Round scheduler for a VGA plotter: clears the screen, then time-slices
// player sprites and a timer bar onto a single registered pixel port.
module draw_scheduler #(
  parameter int NUM_PLAYERS = 4,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int TIMER_ROW = 119,
  parameter int TIMER_LEN = 159,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                             CLOCK_50,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             timer_tick,
  input  logic [NUM_PLAYERS-1:0]           player_en,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0] p_pos,
  input  logic [3*NUM_PLAYERS-1:0]         p_colour,
  output logic [X_W-1:0]                   x,
  output logic [Y_W-1:0]                   y,
  output logic [2:0]                       colour,
  output logic                             plot,
  output logic                             running,
  output logic [X_W-1:0]                   timer_x,
  output logic                             clearing
);

  localparam int PW = X_W + Y_W;
  localparam int SW = $clog2(NUM_PLAYERS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] DRAW  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [X_W-1:0] SX_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] SY_LAST = Y_W'(SCREEN_H - 1);
  localparam logic [X_W-1:0] TL_LAST = X_W'(TIMER_LEN - 1);
  localparam logic [X_W-1:0] TL_END  = X_W'(TIMER_LEN);
  localparam logic [Y_W-1:0] T_ROW   = Y_W'(TIMER_ROW);
  localparam logic [SW-1:0]  SLOT_T  = SW'(NUM_PLAYERS);

  logic [1:0]     state;
  logic [X_W-1:0] sx;
  logic [Y_W-1:0] sy;
  logic [SW-1:0]  slot;

  logic [X_W-1:0] pl_x;
  logic [Y_W-1:0] pl_y;
  logic [2:0]     pl_c;
  logic           pl_en;

  assign clearing = (state == CLEAR);

  // Mux the player slot currently held in the slot counter
  always_comb begin
    pl_x  = '0;
    pl_y  = '0;
    pl_c  = '0;
    pl_en = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (slot == SW'(i)) begin
        pl_x  = p_pos[i*PW+Y_W +: X_W];
        pl_y  = p_pos[i*PW +: Y_W];
        pl_c  = p_colour[3*i +: 3];
        pl_en = player_en[i];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      sx      <= '0;
      sy      <= '0;
      slot    <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      running <= 1'b0;
      timer_x <= '0;
    end else if (start) begin
      state   <= CLEAR;
      sx      <= '0;
      sy      <= '0;
      slot    <= '0;
      plot    <= 1'b0;
      running <= 1'b0;
      timer_x <= '0;
    end else begin
      case (state)
        IDLE: begin
          plot    <= 1'b0;
          running <= 1'b0;
        end
        CLEAR: begin
          x      <= sx;
          y      <= sy;
          colour <= BG_COLOUR;
          plot   <= 1'b1;
          if (sx == SX_LAST) begin
            sx <= '0;
            if (sy == SY_LAST) begin
              sy      <= '0;
              state   <= DRAW;
              slot    <= '0;
              timer_x <= '0;
              running <= 1'b1;
            end else begin
              sy <= sy + 1'b1;
            end
          end else begin
            sx <= sx + 1'b1;
          end
        end
        DRAW: begin
          if (timer_tick && timer_x == TL_LAST) begin
            // Round over: the last registered pixel stands, nothing new plots
            state   <= DONE;
            timer_x <= TL_END;
            running <= 1'b0;
            plot    <= 1'b0;
          end else begin
            if (timer_tick)
              timer_x <= timer_x + 1'b1;
            if (slot == SLOT_T) begin
              x      <= timer_x;
              y      <= T_ROW;
              colour <= 3'b111;
              plot   <= 1'b1;
              slot   <= '0;
            end else begin
              x      <= pl_x;
              y      <= pl_y;
              colour <= pl_c;
              plot   <= pl_en;
              slot   <= slot + 1'b1;
            end
          end
        end
        DONE: begin
          plot    <= 1'b0;
          running <= 1'b0;
          timer_x <= TL_END;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler on a 4x3 screen, 4 players,
// 3-tick rounds and the timer bar on row 2.
module tb_draw_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        timer_tick = 1'b0;
  logic [3:0]  player_en = 4'b1011;
  logic [59:0] p_pos;
  logic [11:0] p_colour;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        running;
  logic [7:0]  timer_x;
  logic        clearing;

  int n_cmp = 0;
  int n_bad = 0;

  draw_scheduler #(
    .NUM_PLAYERS(4), .X_W(8), .Y_W(7),
    .SCREEN_W(4), .SCREEN_H(3),
    .TIMER_ROW(2), .TIMER_LEN(3),
    .BG_COLOUR(3'b000)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start),
    .timer_tick(timer_tick), .player_en(player_en),
    .p_pos(p_pos), .p_colour(p_colour),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .running(running), .timer_x(timer_x),
    .clearing(clearing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Expects the block to have just entered CLEAR at (0,0)
  task automatic do_clear();
    for (int k = 0; k < 12; k++) begin
      step();
      chk("clr_plot", 32'(plot), 32'd1);
      chk("clr_x", 32'(x), 32'(k % 4));
      chk("clr_y", 32'(y), 32'(k / 4));
      chk("clr_col", 32'(colour), 32'd0);
      chk("clr_flag", 32'(clearing), 32'(k < 11));
    end
    chk("clr_run", 32'(running), 32'd1);
  endtask

  // slot order 0..3 then TIMER; {x, y, colour, plot}
  logic [7:0] ex [5];
  logic [6:0] ey [5];
  logic [2:0] ec [5];
  logic       ep [5];

  initial begin
    p_pos = {8'd20, 7'd3, 8'd7, 7'd7, 8'd5, 7'd6, 8'd10, 7'd1};
    p_colour = {3'd4, 3'd3, 3'd2, 3'd1};
    ex = '{8'd10, 8'd5, 8'd7, 8'd20, 8'd0};
    ey = '{7'd1, 7'd6, 7'd7, 7'd3, 7'd2};
    ec = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    ep = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_out", {x, y, colour, plot}, 32'd0);
    chk("rst_run", 32'(running), 32'd0);
    chk("rst_tx", 32'(timer_x), 32'd0);
    chk("rst_clr", 32'(clearing), 32'd0);

    pulse_start();
    chk("st_clr", 32'(clearing), 32'd1);
    chk("st_plot", 32'(plot), 32'd0);
    do_clear();

    // two full frames, slot2 disabled
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 5; s++) begin
        step();
        chk("frm_plot", 32'(plot), 32'(ep[s]));
        if (ep[s]) begin
          chk("frm_x", 32'(x), 32'(ex[s]));
          chk("frm_y", 32'(y), 32'(ey[s]));
          chk("frm_c", 32'(colour), 32'(ec[s]));
        end
      end
    end

    // two ticks, timer pixel at x=1 then x=2
    for (int t = 1; t <= 2; t++) begin
      timer_tick = 1'b1;
      step();
      timer_tick = 1'b0;
      chk("tk_tx", 32'(timer_x), 32'(t));
      for (int s = 0; s < 4; s++) step();
      chk("tk_px", {x, y, colour, plot}, {8'(t), 7'd2, 3'd7, 1'b1});
    end

    // restart mid-round at timer_x=2
    pulse_start();
    chk("rs_clr", 32'(clearing), 32'd1);
    chk("rs_tx", 32'(timer_x), 32'd0);
    chk("rs_run", 32'(running), 32'd0);
    do_clear();

    // three ticks end the round
    for (int t = 1; t <= 3; t++) begin
      timer_tick = 1'b1;
      step();
      timer_tick = 1'b0;
      chk("end_tx", 32'(timer_x), 32'(t));
    end
    chk("end_run", 32'(running), 32'd0);
    chk("end_plot", 32'(plot), 32'd0);
    for (int s = 0; s < 6; s++) begin
      step();
      chk("done_plot", 32'(plot), 32'd0);
      chk("done_tx", 32'(timer_x), 32'd3);
    end

    // restart from DONE, reset at pixel (2,1)
    pulse_start();
    chk("dn_clr", 32'(clearing), 32'd1);
    for (int s = 0; s < 6; s++) step();
    chk("pre_rst_x", 32'(x), 32'd1);
    chk("pre_rst_y", 32'(y), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_out", {x, y, colour, plot}, 32'd0);
    chk("mr_clr", 32'(clearing), 32'd0);
    chk("mr_run", 32'(running), 32'd0);
    timer_tick = 1'b1;
    step();
    timer_tick = 1'b0;
    step();
    chk("idle_tx", 32'(timer_x), 32'd0);
    chk("idle_plot", 32'(plot), 32'd0);

    // start beats a simultaneous tick
    pulse_start();
    do_clear();
    timer_tick = 1'b1;
    step();
    chk("pre_tx", 32'(timer_x), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    timer_tick = 1'b0;
    chk("st_tk_clr", 32'(clearing), 32'd1);
    chk("st_tk_tx", 32'(timer_x), 32'd0);
    step();
    chk("st_tk_px", {x, y, plot}, {8'd0, 7'd0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 4, number of player slots (1..8).
REQ-002 SHALL have parameter X_W, default 8, x coordinate width.
REQ-003 SHALL have parameter Y_W, default 7, y coordinate width.
REQ-004 SHALL have parameter SCREEN_W, default 160, clear-sweep width in pixels.
REQ-005 SHALL have parameter SCREEN_H, default 120, clear-sweep height in pixels.
REQ-006 SHALL have parameter TIMER_ROW, default 119, y row of the timer bar.
REQ-007 SHALL have parameter TIMER_LEN, default 159, timer ticks per round.
REQ-008 SHALL have parameter BG_COLOUR, default 3'b000, clear colour.
REQ-009 SHALL have port CLOCK_50, input, 1, the only clock; all logic on its rising edge.
REQ-010 SHALL have port reset, input, 1, synchronous, active-high.
REQ-011 SHALL have port start, input, 1, one-cycle pulse that begins a round.
REQ-012 SHALL have port timer_tick, input, 1, one-cycle pulse that advances the timer bar.
REQ-013 SHALL have port player_en, input, NUM_PLAYERS, per-slot draw enable.
REQ-014 SHALL have port p_pos, input, NUM_PLAYERS*(X_W+Y_W), slot i at bits [i*(X_W+Y_W) +: X_W+Y_W], with x as the upper X_W bits and y as the lower Y_W bits.
REQ-015 SHALL have port p_colour, input, 3*NUM_PLAYERS, slot i colour at [3i +: 3].
REQ-016 SHALL have port x, output, X_W, pixel x.
REQ-017 SHALL have port y, output, Y_W, pixel y.
REQ-018 SHALL have port colour, output, 3, pixel colour.
REQ-019 SHALL have port plot, output, 1, pixel write strobe for the VGA adapter.
REQ-020 SHALL have port running, output, 1, high while a round is in progress.
REQ-021 SHALL have port timer_x, output, X_W, current timer-bar length.
REQ-022 SHALL have port clearing, output, 1, high during the screen sweep.

Function
REQ-023 SHALL implement states IDLE, CLEAR, DRAW, DONE.
REQ-024 SHALL register x, y, colour and plot; the pixel for a counter/slot value appears on the outputs one cycle after that value is held.
REQ-025 In IDLE, the block SHALL drive plot=0 and running=0; start moves it to CLEAR.
REQ-026 In CLEAR, the block SHALL sweep x 0..SCREEN_W-1 fastest, then y 0..SCREEN_H-1, one pixel per cycle, plot=1, colour=BG_COLOUR, taking exactly SCREEN_W*SCREEN_H cycles.
REQ-027 After pixel (SCREEN_W-1, SCREEN_H-1) is issued, the block SHALL enter DRAW with slot=0, timer_x=0 and running=1.
REQ-028 In DRAW, slot SHALL cycle 0..NUM_PLAYERS-1 then TIMER, then wrap to 0; a frame is NUM_PLAYERS+1 cycles.
REQ-029 For player slot i, the block SHALL output p_pos/p_colour of slot i, with plot=player_en[i]; a disabled slot still consumes its cycle.
REQ-030 For the TIMER slot, the block SHALL output x=timer_x, y=TIMER_ROW, colour=3'b111, plot=1.
REQ-031 In DRAW, timer_tick SHALL increment timer_x by 1; ticks outside DRAW SHALL be ignored.
REQ-032 A tick with timer_x==TIMER_LEN-1 SHALL set timer_x=TIMER_LEN, running=0 and move the block to DONE on that edge; any pixel already registered completes, and no further plot occurs.
REQ-033 In DONE, the block SHALL hold plot=0, running=0 and timer_x=TIMER_LEN.
REQ-034 start in DONE SHALL restart CLEAR.
REQ-035 start in CLEAR or DRAW SHALL restart CLEAR from (0,0) on the next cycle, with running=0 and timer_x=0.
REQ-036 If start and timer_tick arrive together, start SHALL win.
REQ-037 clearing SHALL be 1 exactly while the state is CLEAR.

Reset
REQ-038 reset SHALL take priority over all inputs; on the next edge: state=IDLE, x=0, y=0, colour=0, plot=0, running=0, timer_x=0, slot=0, sweep counters=0; this applies mid-CLEAR or mid-DRAW identically.

Verification (NUM_PLAYERS=4, SCREEN_W=4, SCREEN_H=3, TIMER_LEN=3, TIMER_ROW=2)
REQ-039 Reset then start -> 12 plot cycles, colour 000, (x,y) sequence (0,0),(1,0)..(3,2), clearing=1 throughout, then running=1.
REQ-040 DRAW, player_en=4'b1011, p_pos slot1=(5,6) -> repeating 5-cycle frame; slot2 cycle has plot=0; slot1 cycle shows x=5, y=6 with p_colour[5:3].
REQ-041 Three timer_tick pulses in DRAW -> TIMER-slot pixels at x=0,1,2 on row 2; the third tick gives timer_x=3, running=0, plot=0 thereafter.
REQ-042 start asserted during DRAW at timer_x=2 -> next cycle clearing=1, timer_x=0, sweep restarts at (0,0).
REQ-043 reset asserted during CLEAR at pixel (2,1) -> next cycle all outputs 0 and state IDLE; timer_tick is then ignored.
REQ-044 start and timer_tick in the same cycle in DRAW -> CLEAR entered, timer_x=0.
